// File: rtl/dot_stream_pkg.sv
// dot_stream_pkg
//   Types and constants shared by the streaming dot-product engine. Later
//   matrix-vector blocks will reuse them.
//   dot_state_t : FSM encoding (ACC = accepting pairs, DONE = holding result)
//   acc_width() : width of the full-precision accumulator
package dot_stream_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } dot_state_t;

   // Each product needs 2*entry_size bits. Summing vec_len of them adds
   // clog2(vec_len) carry bits. One extra bit in signed mode covers the
   // (-2^(n-1))^2 corner, so the accumulator never wraps.
   function automatic int acc_width(input int entry_size, input int vec_len,
                                    input int is_signed);
      return 2 * entry_size + $clog2(vec_len) + ((is_signed != 0) ? 1 : 0);
   endfunction

endpackage

// File: rtl/dot_stream_multiplication.sv
// scalar_multiplication
//   Full-precision combinational multiplier, 2*WIDTH result bits.
//   Ports:
//     a, b : WIDTH-bit operands (two's complement when SIGNED != 0)
//     p    : 2*WIDTH-bit exact product (two's complement when SIGNED != 0)
module scalar_multiplication
   import dot_stream_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p
);

   localparam bit SGN = (SIGNED != 0);

   logic [2*WIDTH-1:0] ax;
   logic [2*WIDTH-1:0] bx;

   // Extend both operands to the result width before multiplying. The low
   // 2*WIDTH bits of the product of the extended values are the exact
   // product in either signedness.
   assign ax = {{WIDTH{a[WIDTH-1] & SGN}}, a};
   assign bx = {{WIDTH{b[WIDTH-1] & SGN}}, b};
   assign p  = ax * bx;

endmodule

// File: rtl/dot_stream.sv
// dot_stream
//   Sequential dot-product engine. Element pairs arrive one per cycle. A
//   single multiplier feeds a full-precision accumulator. After VEC_LEN
//   pairs, the wrapped result and an overflow flag are held on the output
//   until the consumer takes them.
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   The producer holds its data stable while valid is high and ready is low.
//   in_ready and out_valid are registered and depend on state only.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     in_valid, in_ready  : input pair handshake
//     a, b                : ENTRY_SIZE-bit elements of vectors a and b
//     out_valid, out_ready: result handshake
//     product             : low RESENTRY_SIZE bits of the exact dot product
//     overflow            : exact dot product does not fit RESENTRY_SIZE bits
module dot_stream
   import dot_stream_pkg::*;
#(
   parameter int ENTRY_SIZE    = 5,
   parameter int RESENTRY_SIZE = 9,
   parameter int VEC_LEN       = 3,
   parameter int SIGNED        = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ENTRY_SIZE-1:0]    a,
   input  logic [ENTRY_SIZE-1:0]    b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [RESENTRY_SIZE-1:0] product,
   output logic                     overflow
);

   localparam int ACC_W = acc_width(ENTRY_SIZE, VEC_LEN, SIGNED);
   // The result is compared in a width wider than both the accumulator and
   // the output, so the bits above the output window always exist.
   localparam int EXT_W = ((ACC_W > RESENTRY_SIZE) ? ACC_W : RESENTRY_SIZE) + 1;
   localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);

   dot_state_t             state;
   logic [IDX_W-1:0]       idx;
   logic [ACC_W-1:0]       acc;
   logic [ACC_W-1:0]       acc_next;
   logic [ACC_W-1:0]       mul_ext;
   logic [2*ENTRY_SIZE-1:0] mul_p;
   logic [EXT_W-1:0]       sum_ext;
   logic                   ovf_next;

   scalar_multiplication #(
      .WIDTH  (ENTRY_SIZE),
      .SIGNED (SIGNED)
   ) u_mul (
      .a (a),
      .b (b),
      .p (mul_p)
   );

   generate
      if (SIGNED != 0) begin : g_signed
         assign mul_ext = ACC_W'($signed(mul_p));
         assign sum_ext = EXT_W'($signed(acc_next));
      end else begin : g_unsigned
         assign mul_ext = ACC_W'(mul_p);
         assign sum_ext = EXT_W'(acc_next);
      end
   endgenerate

   assign acc_next = acc + mul_ext;

   // Unsigned: any set bit above the output window means overflow.
   // Signed: the bits from the output sign bit upward must all be equal.
   always_comb begin
      ovf_next = 1'b0;
      if (SIGNED != 0) begin
         ovf_next = !((&sum_ext[EXT_W-1:RESENTRY_SIZE-1]) ||
                      !(|sum_ext[EXT_W-1:RESENTRY_SIZE-1]));
      end else begin
         ovf_next = |sum_ext[EXT_W-1:RESENTRY_SIZE];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ACC;
         idx       <= '0;
         acc       <= '0;
         product   <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ACC: begin
               if (in_valid && in_ready) begin
                  acc <= acc_next;
                  if (idx == LAST) begin
                     idx       <= '0;
                     product   <= sum_ext[RESENTRY_SIZE-1:0];
                     overflow  <= ovf_next;
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  acc       <= '0;
                  state     <= ACC;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_stream.sv
// tb_dot_stream
//   Bench for dot_stream with three instances: unsigned defaults (0),
//   SIGNED=1 (1), and VEC_LEN=1 (2). The expected results come from a
//   queue-based model. It forms the exact integer dot product of the accepted
//   pairs, then derives the wrapped product and the range-based overflow flag.
module tb_dot_stream;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid [3];
   logic       out_ready[3];
   logic       in_ready [3];
   logic       out_valid[3];
   logic       overflow [3];
   logic [4:0] a_s      [3];
   logic [4:0] b_s      [3];
   logic [8:0] product  [3];

   int tests = 0;
   int fails = 0;
   int qa[3][$];
   int qb[3][$];

   always #5 clk = ~clk;

   dot_stream #(.ENTRY_SIZE(5), .RESENTRY_SIZE(9), .VEC_LEN(3), .SIGNED(0)) u_uns (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .product(product[0]), .overflow(overflow[0]));

   dot_stream #(.ENTRY_SIZE(5), .RESENTRY_SIZE(9), .VEC_LEN(3), .SIGNED(1)) u_sgn (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .product(product[1]), .overflow(overflow[1]));

   dot_stream #(.ENTRY_SIZE(5), .RESENTRY_SIZE(9), .VEC_LEN(1), .SIGNED(0)) u_one (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .product(product[2]), .overflow(overflow[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int vec_len(input int d);
      return (d == 2) ? 1 : 3;
   endfunction

   function automatic longint elem(input int d, input int v);
      if (d == 1 && v >= 16) return longint'(v - 32);
      return longint'(v);
   endfunction

   // Exact dot product of the pairs accepted so far; the queues are then emptied.
   task automatic model(input int d, output logic [31:0] ep, output logic [31:0] eo);
      longint s = 0;
      for (int i = 0; i < qa[d].size(); i++) s += elem(d, qa[d][i]) * elem(d, qb[d][i]);
      ep = 32'(s & 64'sd511);
      if (d == 1) eo = (s < -256 || s > 255) ? 32'd1 : 32'd0;
      else        eo = (s > 511) ? 32'd1 : 32'd0;
      qa[d].delete();
      qb[d].delete();
   endtask

   task automatic send(input int d, input int av, input int bv, input int gap);
      int n = 0;
      a_s[d] = 5'(av);
      b_s[d] = 5'(bv);
      in_valid[d] = 1'b1;
      while (in_ready[d] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n == 20) check("in_ready_timeout", {31'b0, in_ready[d]}, 32'd1);
      step();
      in_valid[d] = 1'b0;
      a_s[d] = 5'($urandom_range(0, 31));
      b_s[d] = 5'($urandom_range(0, 31));
      qa[d].push_back(av & 31);
      qb[d].push_back(bv & 31);
      repeat (gap) step();
   endtask

   // Called right after the last pair is accepted. The result must already be visible.
   task automatic result(input int d, input int hold, input string tag);
      logic [31:0] ep, eo;
      model(d, ep, eo);
      check({tag, "_out_valid"}, {31'b0, out_valid[d]}, 32'd1);
      check({tag, "_in_ready_low"}, {31'b0, in_ready[d]}, 32'd0);
      check({tag, "_product"}, {23'b0, product[d]}, ep);
      check({tag, "_overflow"}, {31'b0, overflow[d]}, eo);
      for (int h = 0; h < hold; h++) begin
         in_valid[d] = 1'b1;
         a_s[d] = 5'($urandom_range(0, 31));
         b_s[d] = 5'($urandom_range(0, 31));
         step();
         check({tag, "_hold_product"}, {23'b0, product[d]}, ep);
         check({tag, "_hold_overflow"}, {31'b0, overflow[d]}, eo);
         check({tag, "_hold_valid"}, {31'b0, out_valid[d]}, 32'd1);
         check({tag, "_hold_in_ready"}, {31'b0, in_ready[d]}, 32'd0);
      end
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      step();
      out_ready[d] = 1'b0;
      check({tag, "_ready_back"}, {31'b0, in_ready[d]}, 32'd1);
      check({tag, "_valid_drop"}, {31'b0, out_valid[d]}, 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         in_valid[d] = 1'b0;
         out_ready[d] = 1'b0;
      end
      for (int c = 0; c < cycles; c++) begin
         step();
         for (int d = 0; d < 3; d++) begin
            check("rst_product", {23'b0, product[d]}, 32'd0);
            check("rst_overflow", {31'b0, overflow[d]}, 32'd0);
            check("rst_out_valid", {31'b0, out_valid[d]}, 32'd0);
         end
      end
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         qa[d].delete();
         qb[d].delete();
      end
      step();
      for (int d = 0; d < 3; d++) begin
         check("post_rst_in_ready", {31'b0, in_ready[d]}, 32'd1);
         check("post_rst_out_valid", {31'b0, out_valid[d]}, 32'd0);
         check("post_rst_product", {23'b0, product[d]}, 32'd0);
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         in_valid[d] = 1'b0;
         out_ready[d] = 1'b0;
         a_s[d] = '0;
         b_s[d] = '0;
      end
      do_reset(3);

      // Unsigned basic vector: expected 32, no overflow.
      send(0, 1, 4, 0);
      send(0, 2, 5, 0);
      send(0, 3, 6, 0);
      result(0, 0, "uns_basic");

      // Maximum operands: 2883 wraps to 323 and overflows.
      send(0, 31, 31, 0);
      send(0, 31, 31, 1);
      send(0, 31, 31, 0);
      result(0, 0, "uns_max");

      // Backpressure: the result is held for 5 cycles while in_valid is pulsed.
      send(0, $urandom_range(0, 31), $urandom_range(0, 31), 0);
      send(0, $urandom_range(0, 31), $urandom_range(0, 31), 0);
      send(0, $urandom_range(0, 31), $urandom_range(0, 31), 0);
      result(0, 5, "uns_bp");

      // Reset after two accepted pairs discards the partial sum (expected 6).
      send(0, 5, 5, 0);
      send(0, 5, 5, 0);
      do_reset(2);
      send(0, 2, 3, 0);
      send(0, 0, 0, 0);
      send(0, 0, 0, 0);
      result(0, 0, "rst_discard");

      // Signed: expected -32 (9'h1E0) without overflow, then 768 with overflow.
      send(1, -1, 4, 0);
      send(1, 2, -5, 0);
      send(1, -3, 6, 0);
      result(1, 0, "sgn_basic");
      send(1, -16, -16, 0);
      send(1, -16, -16, 0);
      send(1, -16, -16, 0);
      result(1, 1, "sgn_max");

      // VEC_LEN=1: every pair yields a result on the next cycle.
      send(2, 7, 3, 0);
      result(2, 0, "one_basic");

      // Randomized vectors with input gaps and output backpressure.
      for (int v = 0; v < 8; v++) begin
         for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < vec_len(d); k++) begin
               send(d, $urandom_range(0, 31), $urandom_range(0, 31),
                    (k == vec_len(d) - 1) ? 0 : $urandom_range(0, 2));
            end
            result(d, $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dot_stream.md
# dot_stream

Sequential, parametrised dot-product engine. It computes dot(a, b) for two VEC_LEN-dimensional vectors whose element pairs arrive one per cycle over a valid/ready stream, accumulating in a multiply-accumulate datapath. The result is presented on a held valid/ready output together with an overflow flag. It replaces the fixed 3-entry combinational dot product wherever vector length, signedness or area (one multiplier instead of VEC_LEN) matters, and sits between the vector-operand sources and the scalar consumers.

## Interface
- ENTRY_SIZE, 5, width of each element of a and b
- RESENTRY_SIZE, 9, width of the delivered product
- VEC_LEN, 3, number of element pairs per dot product (>= 1)
- SIGNED, 0, 0 = unsigned operands/result, 1 = two's-complement operands/result
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  element pair on a/b is valid
- in_ready  out  1  block accepts a pair this cycle
- a  in  ENTRY_SIZE  element of vector a
- b  in  ENTRY_SIZE  element of vector b
- out_valid  out  1  product/overflow valid
- out_ready  in  1  consumer accepts the result
- product  out  RESENTRY_SIZE  low RESENTRY_SIZE bits of the exact dot product
- overflow  out  1  exact dot product not representable in RESENTRY_SIZE bits (per SIGNED)

## Operation
- States: ACC (accepting pairs), DONE (holding result).
- ACC: in_ready=1, out_valid=0. Accept on in_valid && in_ready: acc <= acc + a*b, idx <= idx+1.
- When the accepted pair is the VEC_LEN-th (idx == VEC_LEN-1): register product/overflow from the updated sum, go to DONE, reset idx to 0.
- DONE: in_ready=0, out_valid=1, product/overflow held stable until out_ready. On out_valid && out_ready: acc <= 0, go to ACC.
- Arithmetic: full-precision internal accumulator of width 2*ENTRY_SIZE + clog2(VEC_LEN) + SIGNED; multiply and add signed or unsigned per SIGNED, never truncated internally.
- product = acc[RESENTRY_SIZE-1:0] (wrap-around modulo 2^RESENTRY_SIZE).
- overflow: unsigned -> exact sum > 2^RESENTRY_SIZE - 1; signed -> exact sum outside [-2^(RESENTRY_SIZE-1), 2^(RESENTRY_SIZE-1)-1]. Evaluated on the final sum only.
- in_valid while in_ready=0 is ignored; a/b not sampled.

## Timing
- Reset (synchronous, highest priority): state=ACC, idx=0, acc=0, product=0, overflow=0, out_valid=0; in_ready=1 from the first cycle after reset deasserts. Reset mid-vector discards partial pairs; reset while DONE discards the undelivered result.
- Latency: out_valid rises the cycle after the last pair is accepted.
- Throughput: VEC_LEN + 1 cycles per result with out_ready held high; in_ready returns the cycle after the output handshake.
- in_ready is a pure function of state (no combinational path from out_ready or in_valid).
- VEC_LEN=1: every accepted pair produces a result the next cycle.
- Back-to-back gaps in in_valid are allowed; idx and acc are held across idle cycles.

## Structure
- Shared header/package: state encodings (ACC, DONE) and the accumulator-width expression as a constant function/macro, reused by future matrix-vector blocks.
- One sub-module: the existing scalar_multiplication, instantiated once, widened to full precision (2*ENTRY_SIZE) with SIGNED handling, feeding the accumulator adder.
- Remaining logic (FSM, index counter, accumulator, overflow compare, output register) lives in dot_stream.

## Test plan
- Unsigned defaults, pairs (1,4),(2,5),(3,6) with out_ready=1 -> product=32, overflow=0, out_valid 1 cycle after 3rd accept, in_ready back next cycle.
- Unsigned, three pairs (31,31) -> exact 2883; product=323 (2883 mod 512), overflow=1.
- Backpressure: after result, out_ready=0 for 5 cycles -> product/overflow/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> handshake, in_ready=1 next cycle.
- Reset after 2 accepted pairs (5,5),(5,5), then pairs (2,3),(0,0),(0,0) -> product=6 (partial sum discarded); all outputs 0 during and after reset.
- SIGNED=1, pairs (-1,4),(2,-5),(-3,6) -> exact -32, product=9'h1E0, overflow=0; pairs (-16,-16)x3 -> 768, overflow=1.
- VEC_LEN=1, in_valid gaps: pair (7,3) -> product=21 next cycle; repeated pairs with idle cycles between give one result each.
